seg_mux_display: RTL and testbench

Parametrised, time-multiplexed driver for N common-anode seven-segment digits plus a free-running status blink LED; it generalises the single-digit, switch-driven display path to multiple digits with refresh, ghost-suppression blanking, per-digit blank/blink masks and the 2.4 Hz blink output. It sits at the top of the FPGA design, between the digit-value producers (switches, counters, keypad logic) and the board pins (segment lines, PNP anode drivers, LED).

---
 rtl/seg_disp_pkg.sv | 27 ++
 rtl/seven_segment.sv | 33 +++
 rtl/tick_divider.sv | 43 ++++
 rtl/seg_mux_display.sv | 132 +++++++++++++
 tb/tb_seg_mux_display.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared constants, state type and parameter checks for seg_mux_display
package seg_disp_pkg;

  // All segments dark on a common-anode display (segments are active-low).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Dwell phase: BLANK keeps every anode off while seg settles on the new digit.
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } disp_state_e;

  // Width of a counter running 0..modulus-1; a modulus of 1 still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

  function automatic bit params_legal(input int unsigned num_digits,
                                      input int unsigned digit_cycles,
                                      input int unsigned dead_cycles,
                                      input int unsigned blink_half);
    return (num_digits >= 1) && (num_digits <= 8) &&
           (dead_cycles >= 1) && (dead_cycles < digit_cycles) &&
           (blink_half >= 1);
  endfunction

endpackage

// File: rtl/seven_segment.sv
// rtl/seven_segment.sv - hex to seven-segment decoder, active-low outputs
// Ports:
//   hex_i  4-bit hex value
//   seg_o  segments {g,f,e,d,c,b,a}, 0 = segment lit
module seven_segment (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - wrapping 0..MODULUS-1 counter with terminal-count strobe
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset (count returns to 0)
//   en_i   advance the count this cycle
//   cnt_o  current count
//   tc_o   high when enabled at MODULUS-1, i.e. the count wraps on this edge
module tick_divider
  import seg_disp_pkg::*;
#(
  parameter int unsigned MODULUS = 2,
  parameter int unsigned CNT_W   = cnt_width(MODULUS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o  = en_i && (cnt_q == LAST);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_mux_display.sv
// rtl/seg_mux_display.sv - time-multiplexed common-anode seven-segment driver with blink LED
// Ports:
//   clk         system clock
//   nreset      asynchronous active-low reset
//   digits      hex value per digit, digit k = digits[4k+3:4k]
//   blank_mask  1 = digit k never lit
//   blink_mask  1 = digit k dark while the blink phase is high
//   seg         segment lines, active-low
//   anode       digit enables, active-low
//   blink_led   blink phase, active-high
module seg_mux_display
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned DIGIT_CYCLES = 24000,
  parameter int unsigned DEAD_CYCLES  = 240,
  parameter int unsigned BLINK_HALF   = 5000000
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    blink_led
);

  if (!params_legal(NUM_DIGITS, DIGIT_CYCLES, DEAD_CYCLES, BLINK_HALF)) begin : g_param_check
    $error("seg_mux_display: illegal parameter combination");
  end

  localparam int unsigned CNT_W = cnt_width(DIGIT_CYCLES);
  localparam int unsigned IDX_W = cnt_width(NUM_DIGITS);
  localparam int unsigned BLK_W = cnt_width(BLINK_HALF);
  localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(DEAD_CYCLES);

  logic [CNT_W-1:0]      cnt;
  logic                  dwell_tc;
  logic [IDX_W-1:0]      idx;
  logic                  idx_tc_unused;
  logic [BLK_W-1:0]      blink_cnt_unused;
  logic                  blink_tc;
  disp_state_e           state;
  logic [3:0]            cur_digit;
  logic [6:0]            seg_dec;
  logic                  lit;
  logic                  blink_phase_d;

  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  blink_led_q;

  tick_divider #(.MODULUS(DIGIT_CYCLES)) u_dwell (
    .clk   (clk),
    .rst_n (nreset),
    .en_i  (1'b1),
    .cnt_o (cnt),
    .tc_o  (dwell_tc)
  );

  // Digit index steps once per completed dwell.
  tick_divider #(.MODULUS(NUM_DIGITS)) u_digit (
    .clk   (clk),
    .rst_n (nreset),
    .en_i  (dwell_tc),
    .cnt_o (idx),
    .tc_o  (idx_tc_unused)
  );

  tick_divider #(.MODULUS(BLINK_HALF)) u_blink (
    .clk   (clk),
    .rst_n (nreset),
    .en_i  (1'b1),
    .cnt_o (blink_cnt_unused),
    .tc_o  (blink_tc)
  );

  seven_segment u_dec (
    .hex_i (cur_digit),
    .seg_o (seg_dec)
  );

  assign state = (cnt < DEAD_CNT) ? BLANK : SHOW;

  // Gate the anode with the phase blink_led takes on this same edge, so a
  // blinking digit is never lit in a cycle where blink_led reads high.
  assign blink_phase_d = blink_led_q ^ blink_tc;

  always_comb begin
    cur_digit = 4'h0;
    lit       = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_digit = digits[4*k +: 4];
        lit       = !blank_mask[k] && !(blink_mask[k] && blink_phase_d);
      end
    end
  end

  always_comb begin
    seg_d   = seg_q;
    anode_d = '1;
    if (state == BLANK) begin
      // Anodes off while seg tracks the incoming digit, which suppresses ghosting.
      seg_d = seg_dec;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if ((idx == IDX_W'(k)) && lit) begin
          anode_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      seg_q       <= SEG_OFF;
      anode_q     <= '1;
      blink_led_q <= 1'b0;
    end else begin
      seg_q       <= seg_d;
      anode_q     <= anode_d;
      blink_led_q <= blink_phase_d;
    end
  end

  assign seg       = seg_q;
  assign anode     = anode_q;
  assign blink_led = blink_led_q;

endmodule

// File: tb/tb_seg_mux_display.sv
// tb/tb_seg_mux_display.sv - self-checking bench for seg_mux_display
module tb_seg_mux_display;

  logic       clk = 1'b0;
  logic       nreset;
  logic [7:0] digits;
  logic [1:0] blank_mask;
  logic [1:0] blink_mask;
  logic [6:0] seg;
  logic [1:0] anode;
  logic       blink_led;

  logic [3:0] digits1;
  logic       blank1;
  logic       blink1;
  logic [6:0] seg1;
  logic       anode1;
  logic       blink_led1;

  always #5 clk = ~clk;

  seg_mux_display #(
    .NUM_DIGITS(2), .DIGIT_CYCLES(8), .DEAD_CYCLES(2), .BLINK_HALF(20)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .digits     (digits),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .seg        (seg),
    .anode      (anode),
    .blink_led  (blink_led)
  );

  seg_mux_display #(
    .NUM_DIGITS(1), .DIGIT_CYCLES(8), .DEAD_CYCLES(2), .BLINK_HALF(20)
  ) dut1 (
    .clk        (clk),
    .nreset     (nreset),
    .digits     (digits1),
    .blank_mask (blank1),
    .blink_mask (blink1),
    .seg        (seg1),
    .anode      (anode1),
    .blink_led  (blink_led1)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] an;
    logic       bl;
    logic [6:0] seg1;
    logic       an1;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_edges = 0;
  logic [6:0] m_seg = 7'h7F;
  logic [6:0] m_seg1 = 7'h7F;

  // Independent active-high glyph table, inverted for the common-anode pins.
  function automatic logic [6:0] dec(input logic [3:0] h);
    logic [6:0] ah;
    case (h)
      4'h0: ah = 7'h3F; 4'h1: ah = 7'h06; 4'h2: ah = 7'h5B; 4'h3: ah = 7'h4F;
      4'h4: ah = 7'h66; 4'h5: ah = 7'h6D; 4'h6: ah = 7'h7D; 4'h7: ah = 7'h07;
      4'h8: ah = 7'h7F; 4'h9: ah = 7'h6F; 4'hA: ah = 7'h77; 4'hB: ah = 7'h7C;
      4'hC: ah = 7'h39; 4'hD: ah = 7'h5E; 4'hE: ah = 7'h79; default: ah = 7'h71;
    endcase
    return ~ah;
  endfunction

  // Expected pins after the coming edge, from the edge count since release.
  task automatic model_push();
    int   q;
    int   d;
    logic ph;
    exp_t e;
    n_edges++;
    q  = (n_edges - 1) % 8;
    d  = ((n_edges - 1) / 8) % 2;
    ph = ((n_edges / 20) % 2) == 1;
    e.an  = 2'b11;
    e.an1 = 1'b1;
    if (q < 2) begin
      m_seg  = dec(digits[d*4 +: 4]);
      m_seg1 = dec(digits1);
    end else begin
      if (!blank_mask[d] && !(blink_mask[d] && ph)) e.an[d] = 1'b0;
      e.an1 = 1'b0;
    end
    e.seg  = m_seg;
    e.seg1 = m_seg1;
    e.bl   = ph;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg: got %h want 7f", seg); end
      n_cmp++; if (anode !== 2'b11) begin n_bad++; $display("FAIL reset_anode: got %b want 11", anode); end
      n_cmp++; if (blink_led !== 1'b0) begin n_bad++; $display("FAIL reset_blink: got %b want 0", blink_led); end
      n_cmp++; if (anode1 !== 1'b1) begin n_bad++; $display("FAIL reset_anode1: got %b want 1", anode1); end
    end
    @(negedge clk);
    nreset  = 1'b1;
    n_edges = 0;
    sb_q.delete();
  endtask

  task automatic test_pattern();
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      model_push(); @(posedge clk); #1; e = sb_q.pop_front();
      n_cmp++; if (seg !== e.seg) begin n_bad++; $display("FAIL pattern_seg edge %0d: got %h want %h", n_edges, seg, e.seg); end
      n_cmp++; if (anode !== e.an) begin n_bad++; $display("FAIL pattern_anode edge %0d: got %b want %b", n_edges, anode, e.an); end
    end
  endtask

  task automatic test_digit_change();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      if (n_edges % 16 == 4) break;
      model_push(); @(posedge clk); #1; e = sb_q.pop_front();
      n_cmp++; if (anode !== e.an) begin n_bad++; $display("FAIL align_anode edge %0d: got %b want %b", n_edges, anode, e.an); end
    end
    digits = 8'h35;
    for (int i = 0; i < 24; i++) begin
      model_push(); @(posedge clk); #1; e = sb_q.pop_front();
      n_cmp++; if (seg !== e.seg) begin n_bad++; $display("FAIL change_seg edge %0d: got %h want %h", n_edges, seg, e.seg); end
      n_cmp++; if (anode !== e.an) begin n_bad++; $display("FAIL change_anode edge %0d: got %b want %b", n_edges, anode, e.an); end
    end
  endtask

  task automatic test_blink();
    exp_t e;
    blink_mask = 2'b01;
    for (int i = 0; i < 60; i++) begin
      model_push(); @(posedge clk); #1; e = sb_q.pop_front();
      n_cmp++; if (blink_led !== e.bl) begin n_bad++; $display("FAIL blink_led edge %0d: got %b want %b", n_edges, blink_led, e.bl); end
      n_cmp++; if (anode !== e.an) begin n_bad++; $display("FAIL blink_anode edge %0d: got %b want %b", n_edges, anode, e.an); end
      n_cmp++; if (blink_led === 1'b1 && anode[0] !== 1'b1) begin n_bad++; $display("FAIL blink_dark edge %0d: got anode0 %b want 1", n_edges, anode[0]); end
    end
    blink_mask = 2'b00;
  endtask

  task automatic test_blank_mask();
    exp_t e;
    blank_mask = 2'b10;
    for (int i = 0; i < 32; i++) begin
      model_push(); @(posedge clk); #1; e = sb_q.pop_front();
      n_cmp++; if (anode !== e.an) begin n_bad++; $display("FAIL blank_anode edge %0d: got %b want %b", n_edges, anode, e.an); end
      n_cmp++; if (anode[1] !== 1'b1) begin n_bad++; $display("FAIL blank_digit1 edge %0d: got %b want 1", n_edges, anode[1]); end
    end
    blank_mask = 2'b00;
  endtask

  task automatic test_single_digit();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) digits1 = 4'hC;
      model_push(); @(posedge clk); #1; e = sb_q.pop_front();
      n_cmp++; if (anode1 !== e.an1) begin n_bad++; $display("FAIL single_anode edge %0d: got %b want %b", n_edges, anode1, e.an1); end
      n_cmp++; if (seg1 !== e.seg1) begin n_bad++; $display("FAIL single_seg edge %0d: got %h want %h", n_edges, seg1, e.seg1); end
      n_cmp++; if (blink_led1 !== e.bl) begin n_bad++; $display("FAIL single_blink edge %0d: got %b want %b", n_edges, blink_led1, e.bl); end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      if (n_edges % 8 == 4) break;
      model_push(); @(posedge clk); #1; e = sb_q.pop_front();
      n_cmp++; if (anode !== e.an) begin n_bad++; $display("FAIL prereset_anode edge %0d: got %b want %b", n_edges, anode, e.an); end
    end
    #1 nreset = 1'b0;
    #1;
    n_cmp++; if (anode !== 2'b11) begin n_bad++; $display("FAIL async_anode: got %b want 11", anode); end
    n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL async_seg: got %h want 7f", seg); end
    n_cmp++; if (blink_led !== 1'b0) begin n_bad++; $display("FAIL async_blink: got %b want 0", blink_led); end
    n_cmp++; if (anode1 !== 1'b1) begin n_bad++; $display("FAIL async_anode1: got %b want 1", anode1); end
    @(posedge clk); #1;
    n_cmp++; if (anode !== 2'b11) begin n_bad++; $display("FAIL held_anode: got %b want 11", anode); end
    @(negedge clk);
    nreset  = 1'b1;
    n_edges = 0;
    sb_q.delete();
    for (int i = 0; i < 24; i++) begin
      model_push(); @(posedge clk); #1; e = sb_q.pop_front();
      n_cmp++; if (anode !== e.an) begin n_bad++; $display("FAIL restart_anode edge %0d: got %b want %b", n_edges, anode, e.an); end
      n_cmp++; if (seg !== e.seg) begin n_bad++; $display("FAIL restart_seg edge %0d: got %h want %h", n_edges, seg, e.seg); end
      n_cmp++; if (blink_led !== e.bl) begin n_bad++; $display("FAIL restart_blink edge %0d: got %b want %b", n_edges, blink_led, e.bl); end
    end
  endtask

  initial begin
    nreset     = 1'b0;
    digits     = 8'h3A;
    blank_mask = 2'b00;
    blink_mask = 2'b00;
    digits1    = 4'h5;
    blank1     = 1'b0;
    blink1     = 1'b0;
    test_reset();
    test_pattern();
    test_digit_change();
    test_blink();
    test_blank_mask();
    test_single_digit();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
